// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block: register offsets,
// STATUS/CTRL bit positions and the default MMIO window base.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0] OFF_TIMER    = 8'h08;
    localparam logic [7:0] OFF_TIMECMP  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_CTRL     = 8'h14;

    localparam int unsigned STATUS_MATCH = 0;
    localparam int unsigned STATUS_ERR   = 1;
    localparam int unsigned CTRL_CNT_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;

endpackage

// File: rtl/dmem_timer.sv
// Free-running cycle timer with compare register and sticky match flag.
// Priority: a TIMER write beats the increment; a new match beats a W1C.
module dmem_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cntEn,
    input  logic        timerWe,
    input  logic        cmpWe,
    input  logic        matchClr,
    input  logic [31:0] wdata,
    output logic [31:0] timer,
    output logic [31:0] timeCmp,
    output logic        match
);

    logic [31:0] timerQ, timerD;
    logic [31:0] cmpQ, cmpD;
    logic        matchQ, matchD;

    always_comb begin
        timerD = timerQ;
        if (timerWe) begin
            timerD = wdata;
        end else if (cntEn) begin
            timerD = timerQ + 32'd1;
        end
        cmpD   = cmpWe ? wdata : cmpQ;
        // Compare uses the registered values, so match lands one edge after equality.
        matchD = (timerQ == cmpQ) | (matchQ & ~matchClr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timerQ <= 32'd0;
            cmpQ   <= 32'hFFFF_FFFF;
            matchQ <= 1'b0;
        end else begin
            timerQ <= timerD;
            cmpQ   <= cmpD;
            matchQ <= matchD;
        end
    end

    assign timer   = timerQ;
    assign timeCmp = cmpQ;
    assign match   = matchQ;

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (GPIO, timer, status/control) behind the core's
// Memory stage. Loads are combinational; stores commit on the rising edge.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT,
    parameter int unsigned GPIO_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq_timer
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RamBytes = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [IdxW-1:0]   ramIdx;
    logic [5:0]        regSel;
    logic              isRam, isMmio;
    logic              ramWe, unmappedWe;
    logic              gpioOutWe, timerWe, cmpWe, statusWe, ctrlWe;
    logic [GPIO_W-1:0] gpioOutQ, gpioSync1Q, gpioSync2Q;
    logic [1:0]        ctrlQ;
    logic              errQ, errD;
    logic              match, matchClr;
    logic [31:0]       timer, timeCmp, statusWord;

    assign isRam  = ALUResultM < RamBytes;
    assign isMmio = ALUResultM[31:8] == MMIO_BASE[31:8];
    assign ramIdx = ALUResultM[IdxW+1:2];
    assign regSel = ALUResultM[7:2];

    assign ramWe      = MemWriteM & isRam;
    assign unmappedWe = MemWriteM & ~isRam & ~isMmio;
    assign gpioOutWe  = MemWriteM & isMmio & (regSel == OFF_GPIO_OUT[7:2]);
    assign timerWe    = MemWriteM & isMmio & (regSel == OFF_TIMER[7:2]);
    assign cmpWe      = MemWriteM & isMmio & (regSel == OFF_TIMECMP[7:2]);
    assign statusWe   = MemWriteM & isMmio & (regSel == OFF_STATUS[7:2]);
    assign ctrlWe     = MemWriteM & isMmio & (regSel == OFF_CTRL[7:2]);

    assign matchClr = statusWe & WriteDataM[STATUS_MATCH];
    // A fresh unmapped store outranks a same-cycle clear.
    assign errD     = unmappedWe | (errQ & ~(statusWe & WriteDataM[STATUS_ERR]));

    // RAM has no reset; contents persist across reset.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[ramIdx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpioOutQ   <= '0;
            gpioSync1Q <= '0;
            gpioSync2Q <= '0;
            ctrlQ      <= 2'b01;
            errQ       <= 1'b0;
        end else begin
            if (gpioOutWe) begin
                gpioOutQ <= WriteDataM[GPIO_W-1:0];
            end
            if (ctrlWe) begin
                ctrlQ <= WriteDataM[1:0];
            end
            gpioSync1Q <= gpio_in;
            gpioSync2Q <= gpioSync1Q;
            errQ       <= errD;
        end
    end

    dmem_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .cntEn    (ctrlQ[CTRL_CNT_EN]),
        .timerWe  (timerWe),
        .cmpWe    (cmpWe),
        .matchClr (matchClr),
        .wdata    (WriteDataM),
        .timer    (timer),
        .timeCmp  (timeCmp),
        .match    (match)
    );

    always_comb begin
        statusWord               = '0;
        statusWord[STATUS_MATCH] = match;
        statusWord[STATUS_ERR]   = errQ;
    end

    always_comb begin
        ReadDataM = '0;
        if (isRam) begin
            ReadDataM = mem[ramIdx];
        end else if (isMmio) begin
            case (regSel)
                OFF_GPIO_OUT[7:2]: ReadDataM = 32'(gpioOutQ);
                OFF_GPIO_IN[7:2]:  ReadDataM = 32'(gpioSync2Q);
                OFF_TIMER[7:2]:    ReadDataM = timer;
                OFF_TIMECMP[7:2]:  ReadDataM = timeCmp;
                OFF_STATUS[7:2]:   ReadDataM = statusWord;
                OFF_CTRL[7:2]:     ReadDataM = {30'd0, ctrlQ};
                default:           ReadDataM = '0;
            endcase
        end
    end

    assign gpio_out  = gpioOutQ;
    assign irq_timer = match & ctrlQ[CTRL_IRQ_EN];

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem that sits directly downstream of the pipelined core's Memory stage.
- Consumes the core's MemWriteM, ALUResultM (address) and WriteDataM, and returns ReadDataM within the same cycle.
- Contains a word-addressed data RAM plus a small memory-mapped I/O block: GPIO, free-running cycle timer, compare, status/control, and a timer interrupt line.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- MMIO_BASE, 32'hFFFF_FF00, base of the 256-byte MMIO window.
- GPIO_W, 8, width of the GPIO input and output buses.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWriteM  input  1  write strobe from the Memory stage.
- ALUResultM  input  32  byte address.
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data, combinational from the current address.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- gpio_out  output  GPIO_W  registered GPIO output.
- irq_timer  output  1  level interrupt = STATUS.match & CTRL.irq_en.

Behaviour:
- Reset is synchronous and active-high, on clk. At reset:
  - gpio_out=0, TIMER=0, TIMECMP=32'hFFFF_FFFF, STATUS=0, CTRL=2'b01 (count enabled, irq disabled), both gpio_in sync flops=0.
  - irq_timer is therefore 0.
  - RAM contents are not reset.
- Addressing is word-granular: index = ALUResultM[31:2]; ALUResultM[1:0] are ignored. There are no byte enables; every store writes a full word.
- Region decode:
  - RAM when ALUResultM < 4*DEPTH_WORDS.
  - MMIO when ALUResultM[31:8] == MMIO_BASE[31:8].
  - Everything else is unmapped.
- Reads are combinational, zero latency: ReadDataM is valid in the same cycle as the address, because the core samples it in the M stage.
- Writes take effect at the rising edge when MemWriteM=1. A read of the same address in the same cycle returns the old value.
- MMIO map (offset from MMIO_BASE):
  - 0x00 GPIO_OUT, RW.
  - 0x04 GPIO_IN, RO; value is the output of the 2-flop synchronizer, zero-extended; writes ignored.
  - 0x08 TIMER, RW; a write loads the counter.
  - 0x0C TIMECMP, RW.
  - 0x10 STATUS, bit0 match, bit1 err. Both sticky; write-1-to-clear per bit.
  - 0x14 CTRL, bit0 cnt_en, bit1 irq_en; RW; upper bits read 0.
  - Any other offset reads 0; writes to it are ignored.
- Unmapped region: reads return 0. A write sets STATUS.err at the next edge; memory is unchanged.
- TIMER:
  - Increments by 1 each cycle while cnt_en=1.
  - Wraps from 32'hFFFF_FFFF to 0 with no flag.
  - A TIMER write in the same cycle as an increment: the write wins, loads WriteDataM exactly, and no increment occurs that cycle.
- Match:
  - When the registered TIMER == TIMECMP, STATUS.match is set at the next edge, regardless of cnt_en.
  - If a W1C of match and a new match occur in the same cycle, the set wins.
  - The same priority applies to err: a W1C versus an unmapped write in the same cycle leaves err set.
- irq_timer is combinational from the registered STATUS and CTRL; it has no extra latency.
- The gpio_in synchronizer runs every cycle, so a change on gpio_in is visible at GPIO_IN 2 cycles later.
- Reset asserted mid-operation: any write in the reset cycle is discarded for MMIO registers. A RAM write in that cycle is permitted but unspecified; the bench must not check it.

Decomposition:
- Shared package holds:
  - the MMIO offset constants (OFF_GPIO_OUT, OFF_GPIO_IN, OFF_TIMER, OFF_TIMECMP, OFF_STATUS, OFF_CTRL);
  - the STATUS/CTRL bit indices;
  - the MMIO_BASE default.
- One sub-module is natural: dmem_timer, holding TIMER, TIMECMP, the match logic and its write/increment/W1C priority.
- RAM, decode, GPIO and the read mux stay in the top.

Test Plan:
- RAM store/load:
  - Write 32'hDEAD_BEEF to 0x0000_0010, then read 0x10 → ReadDataM=32'hDEAD_BEEF.
  - Read 0x13 → same word, since the low address bits are ignored.
- Unmapped and W1C:
  - Write to 0x0001_0000 → next read of STATUS (0xFFFF_FF10)=32'h2, and RAM is unchanged.
  - Write 32'h2 to STATUS → reads 0.
- Timer load versus increment:
  - With cnt_en=1, write 32'hFFFF_FFFE to TIMER. Over the following cycles TIMER reads 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000.
  - The wrap leaves STATUS.match=0 while TIMECMP=32'h0000_0100.
- Compare/interrupt:
  - Set TIMECMP=5, TIMER=0, CTRL=3 → STATUS.match sets exactly one cycle after TIMER reads 5, and irq_timer rises in that same cycle.
  - W1C in a cycle where TIMER==TIMECMP again keeps match=1.
- GPIO:
  - Write 8'hA5 to GPIO_OUT → gpio_out=8'hA5 next cycle.
  - Drive gpio_in=8'h3C → GPIO_IN reads 32'h3C two cycles later, and 0 in the cycle before that.
- Mid-run reset:
  - Assert reset for 1 cycle while TIMER=1000 and gpio_out=8'hFF → TIMER=0, gpio_out=0, CTRL=1, irq_timer=0.
  - An MMIO write issued in the reset cycle is ignored.
